fm_data_mover: RTL



---
 rtl/fm_data_mover.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fm_data_mover.sv
// Pairs sequencer read/write strobes into source reads and destination writes; a write lands RD_LAT+2 cycles after its read strobe.
// No backpressure: every stage shifts each cycle, and unpaired items raise a sticky error and are dropped.
module fm_data_mover #(
    parameter int AW     = 17,
    parameter int DW     = 64,
    parameter int RD_LAT = 2,
    parameter int W_CNT  = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_mv_start,
    input  logic             i_as_done,
    input  logic             i_as_rd_vld,
    input  logic [AW-1:0]    i_as_rd_addr,
    input  logic             i_as_wr_vld,
    input  logic [AW-1:0]    i_as_wr_addr,
    output logic             o_src_rd_en,
    output logic [AW-1:0]    o_src_rd_addr,
    input  logic [DW-1:0]    i_src_rd_data,
    output logic             o_dst_wr_en,
    output logic [AW-1:0]    o_dst_wr_addr,
    output logic [DW-1:0]    o_dst_wr_data,
    output logic             o_mv_busy,
    output logic             o_mv_done,
    output logic [W_CNT-1:0] o_wr_count,
    output logic             o_err
);
    localparam int WA_W = RD_LAT * AW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;

    logic            accept;
    logic            acc_rd;
    logic            acc_wr;
    logic            start_acc;
    logic [RD_LAT-1:0] dv_sr;
    logic [RD_LAT-1:0] wv_sr;
    logic [WA_W-1:0] wa_sr;
    logic            dvld;
    logic            wvld;
    logic            pair;
    logic [AW-1:0]   waddr;
    logic            drained;

    assign accept    = (state == RUN) || (state == DRAIN);
    assign acc_rd    = accept && i_as_rd_vld;
    assign acc_wr    = accept && i_as_wr_vld;
    assign start_acc = (state == IDLE) && q_mv_start;

    assign dvld  = dv_sr[RD_LAT-1];
    assign wvld  = wv_sr[RD_LAT-1];
    assign waddr = wa_sr[WA_W-1 -: AW];
    assign pair  = dvld && wvld;

    // The last write is on the outputs in the cycle the FSM leaves DRAIN, so done follows it by one cycle.
    assign drained = !o_src_rd_en && !(|dv_sr) && !(|wv_sr) && !i_as_rd_vld && !i_as_wr_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            o_mv_busy <= 1'b0;
            o_mv_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_mv_done <= 1'b0;
                    if (q_mv_start) begin
                        state     <= RUN;
                        o_mv_busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_as_done) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state     <= DONE;
                        o_mv_busy <= 1'b0;
                        o_mv_done <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    o_mv_done <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    o_mv_busy <= 1'b0;
                    o_mv_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_src_rd_en   <= 1'b0;
            o_src_rd_addr <= '0;
            dv_sr         <= '0;
            wv_sr         <= '0;
            wa_sr         <= '0;
            o_dst_wr_en   <= 1'b0;
            o_dst_wr_addr <= '0;
            o_dst_wr_data <= '0;
            o_wr_count    <= '0;
            o_err         <= 1'b0;
        end else begin
            o_src_rd_en <= acc_rd;
            if (acc_rd) begin
                o_src_rd_addr <= i_as_rd_addr;
            end

            // Oldest entry sits in the top slot; the new one enters at the bottom.
            dv_sr <= RD_LAT'({dv_sr, o_src_rd_en});
            wv_sr <= RD_LAT'({wv_sr, acc_wr});
            wa_sr <= WA_W'({wa_sr, i_as_wr_addr});

            o_dst_wr_en <= pair;
            if (pair) begin
                o_dst_wr_addr <= waddr;
                o_dst_wr_data <= i_src_rd_data;
            end

            if (start_acc) begin
                o_wr_count <= '0;
            end else if (pair && (o_wr_count != '1)) begin
                o_wr_count <= o_wr_count + W_CNT'(1);
            end

            if (start_acc) begin
                o_err <= 1'b0;
            end else if (dvld != wvld) begin
                o_err <= 1'b1;
            end
        end
    end
endmodule
